// File: rtl/fetch.sv
// Instruction-fetch stage: owns the PC, keeps one request outstanding to instruction
// memory, and feeds decode through a registered output slot backed by a one-entry skid.
module fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic        instr_valid
);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } slot_t;

  slot_t       r_out, r_sk, w_out_nxt, w_sk_nxt, w_rsp_slot;
  logic        r_out_valid, r_sk_valid, w_out_valid_nxt, w_sk_valid_nxt;
  logic [31:0] r_fpc, r_pend_pc, w_fpc_nxt, w_pend_pc_nxt;
  logic        r_pend, r_drop, w_pend_nxt, w_drop_nxt;
  logic        w_accept, w_rsp, w_deliver, w_consume;

  // Gating with rst keeps the request low while reset is held and lets it rise
  // combinationally in the first cycle after release.
  assign imem_req_valid = rst && !r_pend && !r_sk_valid && !redirect;
  assign imem_addr      = r_fpc;

  assign w_accept   = imem_req_valid && imem_req_ready;
  assign w_rsp      = imem_rsp_valid && r_pend;
  assign w_deliver  = w_rsp && !r_drop;
  assign w_consume  = r_out_valid && !stall;
  assign w_rsp_slot = '{instr: imem_rsp_data, pc: r_pend_pc};

  always_comb begin
    // NOTE: every next-state signal gets its hold value first, so no path can infer a latch.
    w_fpc_nxt       = r_fpc;
    w_pend_nxt      = r_pend;
    w_drop_nxt      = r_drop;
    w_pend_pc_nxt   = r_pend_pc;
    w_out_nxt       = r_out;
    w_out_valid_nxt = r_out_valid;
    w_sk_nxt        = r_sk;
    w_sk_valid_nxt  = r_sk_valid;

    if (w_rsp) w_pend_nxt = 1'b0;

    if (redirect) begin
      w_fpc_nxt       = redirect_pc & ~32'h3;
      w_drop_nxt      = r_pend && !imem_rsp_valid;
      w_out_nxt.instr = NOP;
      w_out_valid_nxt = 1'b0;
      w_sk_valid_nxt  = 1'b0;
    end else begin
      if (w_accept) begin
        w_pend_nxt    = 1'b1;
        w_pend_pc_nxt = r_fpc;
        w_fpc_nxt     = r_fpc + 32'd4;
      end
      if (w_rsp) w_drop_nxt = 1'b0;

      if (w_consume) begin
        if (r_sk_valid) begin
          w_out_nxt      = r_sk;
          w_sk_valid_nxt = w_deliver;
          if (w_deliver) w_sk_nxt = w_rsp_slot;
        end else if (w_deliver) begin
          w_out_nxt = w_rsp_slot;
        end else begin
          w_out_valid_nxt = 1'b0;
          w_out_nxt.instr = NOP;
        end
      end else if (w_deliver) begin
        if (r_out_valid) begin
          w_sk_nxt       = w_rsp_slot;
          w_sk_valid_nxt = 1'b1;
        end else begin
          w_out_nxt       = w_rsp_slot;
          w_out_valid_nxt = 1'b1;
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fpc       <= RESET_PC;
      r_pend      <= 1'b0;
      r_drop      <= 1'b0;
      r_pend_pc   <= RESET_PC;
      r_out       <= '{instr: NOP, pc: RESET_PC};
      r_out_valid <= 1'b0;
      r_sk_valid  <= 1'b0;
    end else begin
      r_fpc       <= w_fpc_nxt;
      r_pend      <= w_pend_nxt;
      r_drop      <= w_drop_nxt;
      r_pend_pc   <= w_pend_pc_nxt;
      r_out       <= w_out_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_sk_valid  <= w_sk_valid_nxt;
    end
  end

  // NOTE: skid payload is never read unless r_sk_valid is set, so it carries no reset.
  always_ff @(posedge clk) begin
    r_sk <= w_sk_nxt;
  end

  assign instr       = r_out.instr;
  assign pc          = r_out.pc;
  assign instr_valid = r_out_valid;

endmodule

// File: tb/tb_fetch.sv
// Self-checking bench for fetch: a transaction-level model (memory with random latency,
// a queue of buffered instructions, and an epoch per redirect) checked every cycle.
module tb_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0100;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        stall, redirect;
  logic [31:0] redirect_pc;
  logic [31:0] instr, pc;
  logic        instr_valid;

  always #5 clk = ~clk;

  fetch #(.RESET_PC(RESET_PC), .NOP(NOP)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .stall          (stall),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .instr          (instr),
    .pc             (pc),
    .instr_valid    (instr_valid)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } slot_t;

  // Reference model state
  slot_t       q[$];          // instructions buffered for decode, oldest first
  logic [31:0] m_fpc;         // next address the stage should request
  int          epoch;         // bumped on every redirect/reset
  bit          mem_busy;
  logic [31:0] mem_addr;
  int          mem_wait;
  int          mem_epoch;
  logic [31:0] acc_log[$];    // every accepted request address

  // Stimulus knobs: -1 means random
  int          f_stall = -1, f_redirect = -1, f_ready = -1, f_lat = -1;
  bit          f_spur = 1'b1, f_late = 1'b0;
  logic [31:0] f_rp = '0;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  function automatic logic [31:0] rand_target();
    logic [31:0] t;
    if ($urandom_range(0, 7) == 0) t = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
    else                           t = 32'($urandom_range(0, 32'h0000_FFFF));
    return t;
  endfunction

  task automatic model_reset();
    q.delete();
    m_fpc    = RESET_PC;
    epoch++;
    mem_busy = 1'b0;
    mem_wait = 0;
  endtask

  // One clock cycle: drive at posedge+1, compare and advance the model at negedge.
  task automatic step();
    bit acc, rsp, exp_req;
    stall          = (f_stall < 0)    ? ($urandom_range(0, 3) == 0)  : (f_stall != 0);
    redirect       = (f_redirect < 0) ? ($urandom_range(0, 15) == 0) : (f_redirect != 0);
    redirect_pc    = (f_redirect < 0) ? rand_target() : f_rp;
    imem_req_ready = (f_ready < 0)    ? ($urandom_range(0, 3) != 0)  : (f_ready != 0);
    if (f_late) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = $urandom;
    end else if (mem_busy && mem_wait == 0) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(mem_addr);
    end else begin
      imem_rsp_valid = !mem_busy && f_spur && ($urandom_range(0, 7) == 0);
      imem_rsp_data  = $urandom;
    end

    @(negedge clk);
    check("instr_valid", 32'(instr_valid), 32'(q.size() > 0));
    if (q.size() > 0) begin
      check("instr", instr, q[0].instr);
      check("pc", pc, q[0].pc);
    end else begin
      check("instr_nop", instr, NOP);
    end
    exp_req = !mem_busy && (q.size() < 2) && !redirect;
    check("req_valid", 32'(imem_req_valid), 32'(exp_req));
    if (exp_req) check("req_addr", imem_addr, m_fpc);

    acc = imem_req_valid && imem_req_ready;
    rsp = mem_busy && imem_rsp_valid;
    if (acc) acc_log.push_back(imem_addr);
    if (redirect) begin
      q.delete();
      epoch++;
      m_fpc = redirect_pc & ~32'h3;
    end else begin
      if (q.size() > 0 && !stall) void'(q.pop_front());
      if (rsp && mem_epoch == epoch) q.push_back('{pc: mem_addr, instr: mem_word(mem_addr)});
      if (acc) m_fpc = m_fpc + 32'd4;
    end
    if (rsp)           mem_busy = 1'b0;
    else if (mem_busy) mem_wait--;
    if (acc) begin
      mem_busy  = 1'b1;
      mem_addr  = imem_addr;
      mem_epoch = epoch;
      mem_wait  = (f_lat < 0) ? $urandom_range(0, 2) : f_lat;
    end

    @(posedge clk);
    #1;
  endtask

  task automatic set_knobs(input int s, input int r, input int rdy, input int lat);
    f_stall = s; f_redirect = r; f_ready = rdy; f_lat = lat;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    logic [31:0] a0, e1;
    rst = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    epoch = 0;
    model_reset();

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_instr_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", instr, NOP);
    check("rst_pc", pc, RESET_PC);
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);

    // Boot with a 1-cycle memory
    rst = 1'b1;
    set_knobs(0, 0, 1, 0);
    f_spur = 1'b0;
    #1;
    check("boot_req_valid", 32'(imem_req_valid), 32'd1);
    check("boot_addr", imem_addr, RESET_PC);
    step();
    check("boot_iv_c1", 32'(instr_valid), 32'd0);
    step();
    check("boot_iv_c2", 32'(instr_valid), 32'd1);
    check("boot_pc", pc, RESET_PC);
    check("boot_instr", instr, mem_word(RESET_PC));
    repeat (6) step();
    check("boot_nreq", 32'(acc_log.size() >= 3), 32'd1);
    if (acc_log.size() >= 3) begin
      check("boot_a0", acc_log[0], 32'h100);
      check("boot_a1", acc_log[1], 32'h104);
      check("boot_a2", acc_log[2], 32'h108);
    end

    // Stall long enough for the skid to fill
    set_knobs(1, 0, 1, 0);
    repeat (4) step();
    check("skid_blocks_req", 32'(imem_req_valid), 32'd0);
    e1 = (q.size() == 2) ? q[1].pc : 32'hDEAD_BEEF;
    set_knobs(0, 0, 1, 0);
    step();
    check("skid_out_valid", 32'(instr_valid), 32'd1);
    check("skid_out_pc", pc, e1);

    // Redirect while a request to 0x200 is outstanding
    set_knobs(0, 1, 1, 2);
    f_rp = 32'h200;
    step();
    f_redirect = 0;
    for (int i = 0; i < 12 && !(mem_busy && mem_addr == 32'h200); i++) step();
    check("rd_200_pending", 32'(mem_busy && mem_addr == 32'h200), 32'd1);
    idx = acc_log.size();
    f_redirect = 1;
    f_rp = 32'h403;
    step();
    set_knobs(0, 0, 1, 0);
    for (int i = 0; i < 20 && !(instr_valid && acc_log.size() > idx); i++) step();
    check("rd_next_req_seen", 32'(acc_log.size() > idx), 32'd1);
    if (acc_log.size() > idx) check("rd_next_req", acc_log[idx], 32'h400);
    check("rd_first_pc", pc, 32'h400);

    // Redirect in the same cycle as a response, with stall asserted
    set_knobs(1, 0, 1, 1);
    for (int i = 0; i < 30 && !(q.size() > 0 && mem_busy && mem_wait == 0); i++) step();
    check("sim_setup", 32'(q.size() > 0 && mem_busy && mem_wait == 0), 32'd1);
    f_redirect = 1;
    f_rp = 32'h501;
    step();
    check("sim_iv", 32'(instr_valid), 32'd0);
    check("sim_instr", instr, NOP);
    idx = acc_log.size();
    set_knobs(0, 0, 1, 0);
    for (int i = 0; i < 10 && acc_log.size() <= idx; i++) step();
    check("sim_next_req_seen", 32'(acc_log.size() > idx), 32'd1);
    if (acc_log.size() > idx) check("sim_next_req", acc_log[idx], 32'h500);

    // Backpressure: request must hold steady
    set_knobs(0, 0, 0, 0);
    for (int i = 0; i < 10 && !imem_req_valid; i++) step();
    a0 = m_fpc;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_req_valid", 32'(imem_req_valid), 32'd1);
      check("bp_addr", imem_addr, a0);
    end

    // PC wrap
    set_knobs(0, 1, 1, 0);
    f_rp = 32'hFFFF_FFF9;
    step();
    f_redirect = 0;
    idx = acc_log.size();
    for (int i = 0; i < 20 && acc_log.size() < idx + 3; i++) step();
    check("wrap_nreq", 32'(acc_log.size() >= idx + 3), 32'd1);
    if (acc_log.size() >= idx + 3) begin
      check("wrap_a0", acc_log[idx],     32'hFFFF_FFF8);
      check("wrap_a1", acc_log[idx + 1], 32'hFFFF_FFFC);
      check("wrap_a2", acc_log[idx + 2], 32'h0000_0000);
    end

    // Randomized traffic
    set_knobs(-1, -1, -1, -1);
    f_spur = 1'b1;
    repeat (4000) step();

    // Reset with a request outstanding, then a late response
    set_knobs(0, 0, 1, 2);
    f_spur = 1'b0;
    for (int i = 0; i < 20 && !(mem_busy && mem_wait > 0); i++) step();
    check("mid_pending", 32'(mem_busy), 32'd1);
    rst = 1'b0;
    #1;
    check("mid_rst_iv", 32'(instr_valid), 32'd0);
    check("mid_rst_instr", instr, NOP);
    check("mid_rst_pc", pc, RESET_PC);
    check("mid_rst_req", 32'(imem_req_valid), 32'd0);
    model_reset();
    imem_rsp_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    f_late = 1'b1;
    step();
    f_late = 1'b0;
    check("late_rsp_ignored", 32'(instr_valid), 32'd0);
    repeat (10) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch.md
# fetch

Instruction-fetch stage of the RISC-V core, directly upstream of `decode`. It owns the program counter and issues word requests to instruction memory over a valid/ready handshake, allowing one outstanding request. It presents each returned instruction and its PC to `decode` through a registered IF/ID output backed by a one-entry skid buffer. It also handles pipeline stalls and branch/jump redirects, including discarding any in-flight response after a redirect.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC of the first fetch after reset.
- `NOP`, default 32'h0000_0013: instruction word driven on `instr` while the output slot is empty (`addi x0,x0,0`).

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `imem_req_valid`  out  1  request to instruction memory.
- `imem_req_ready`  in  1  memory accepts the request this cycle.
- `imem_addr`  out  32  word-aligned fetch address.
- `imem_rsp_valid`  in  1  response data valid; arrives at least 1 cycle after its accepted request.
- `imem_rsp_data`  in  32  instruction word.
- `stall`  in  1  `decode` cannot consume this cycle.
- `redirect`  in  1  take `redirect_pc` (branch/jump/exception).
- `redirect_pc`  in  32  new fetch address; bits [1:0] are ignored and treated as 0.
- `instr`  out  32  instruction to `decode`.
- `pc`  out  32  address of `instr`.
- `instr_valid`  out  1  `instr`/`pc` hold a live instruction.

## Operation
- **Registers:**
  - `fpc`: next address to request.
  - `pend`: one request outstanding.
  - `drop`: the outstanding response must be discarded.
  - Output slot: `instr`, `pc`, `instr_valid`.
  - Skid slot: `sk_instr`, `sk_pc`, `sk_valid`.
  - `pend_pc`: address of the outstanding request.
- **Request issue:** `imem_req_valid = !pend && !sk_valid && !redirect`, and `imem_addr = fpc`.
- **Request accept** (`imem_req_valid && imem_req_ready`): set `pend`, `pend_pc <= fpc`, and `fpc <= fpc + 4` (mod 2^32, wraps 0xFFFF_FFFC -> 0).
- **Response** (`imem_rsp_valid && pend`): clear `pend`.
  - If `drop` is set: clear `drop` and discard the data.
  - Otherwise the word `{imem_rsp_data, pend_pc}` is delivered:
    - to the output slot if the slot is empty or is being consumed this cycle;
    - otherwise to the skid slot.
- `imem_rsp_valid` while `!pend` is ignored.
- **Consume:** the output slot is consumed when `instr_valid && !stall`. On consume:
  - the skid entry, if present, moves to the output slot and the skid clears;
  - else a same-cycle response loads the output slot;
  - else `instr_valid <= 0` and `instr <= NOP`.
- **Stall:** output and skid hold their values; the response path still fills the skid. No new request is issued while the skid is full.
- **Redirect** (highest priority, same-edge):
  - `fpc <= redirect_pc & ~3`.
  - Output and skid are cleared: `instr_valid = 0`, `sk_valid = 0`, `instr = NOP`.
  - If `pend` is set and no response arrives this cycle, set `drop`.
  - A response arriving in the redirect cycle is discarded.
  - `stall` is ignored during redirect.
- **Ordering:** instructions reach `decode` in request order. At most 2 instructions are buffered (output + skid).

## Timing
- **Reset values** (asynchronous, while `rst=0`):
  - `fpc = RESET_PC`, `pend = 0`, `drop = 0`, `sk_valid = 0`.
  - `instr_valid = 0`, `instr = NOP`, `pc = RESET_PC`.
  - `imem_req_valid = 0`.
- **First request:** `imem_req_valid` rises combinationally in the first cycle after `rst` deasserts.
- **Latency:** with a 1-cycle memory, the request is accepted at edge N, the response is valid in cycle N+1, and `instr_valid` is high after edge N+1.
- **Throughput:** one instruction every 2 cycles with a 1-cycle memory, because of the single outstanding request.
- **Combinational paths:** `imem_req_valid` depends combinationally on `redirect`. `instr`, `pc` and `instr_valid` are purely registered.
- **Reset during operation:** reset mid-request abandons the outstanding request. Any response arriving after reset is ignored, because `pend` = 0.

## Test plan
- **Reset/boot:** `RESET_PC`=0x100, 1-cycle memory, `stall=0` -> addresses 0x100, 0x104, 0x108 in order; `pc`/`instr` match each word; `instr_valid` is first high 2 cycles after reset release.
- **Stall with skid:** hold `stall` for 4 cycles while a response returns -> output unchanged, skid captures the next word, no request issued while skid is full; after release the two words appear on consecutive cycles with no loss or duplication.
- **Redirect with pending request:** request to 0x200 outstanding; assert `redirect`, `redirect_pc`=0x403 -> the 0x200 response is discarded, the next request is to 0x400, and `instr_valid` stays 0 until the 0x400 word arrives.
- **Simultaneous events:** redirect in the same cycle as a response plus stall -> response dropped, output set to `NOP` with `instr_valid` 0, next request to `redirect_pc`.
- **Backpressure:** `imem_req_ready` held low for 5 cycles -> `imem_req_valid` and `imem_addr` stay stable and `fpc` does not advance; PC wraps 0xFFFF_FFFC -> 0x0000_0000.
- **Reset mid-request:** assert `rst` with a request outstanding -> all outputs return to their reset values immediately; a late `imem_rsp_valid` after release is ignored.
